// File: rtl/snake_block_painter_pkg.sv
// -----------------------------------------------------------------------------
// snake_gfx_pkg
// Shared types and constants for the snake game block painter.
//   state_t     : painter FSM states
//   key_t       : latched block request {base x, base y, effective colour}
//   SCREEN_W/H  : visible screen size in pixels
//   BLOCK_LOG2  : log2 of the block edge (4x4 blocks)
// -----------------------------------------------------------------------------
package snake_gfx_pkg;

    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int BLOCK_LOG2 = 2;
    localparam int BLOCK_EDGE = 1 << BLOCK_LOG2;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PAINT      = 3'd1,
        HOLD       = 3'd2,
        CLEAR      = 3'd3,
        CLEAR_HOLD = 3'd4
    } state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } key_t;

endpackage

// File: rtl/snake_block_painter_if.sv
// -----------------------------------------------------------------------------
// snake_block_painter_if
// Bundle between the game controller (master) and the block painter (slave).
//   Command side : x_count, y_count, colour, load_x, load_y, draw, erase,
//                  plot, restart_game (driven by the controller)
//   Pixel side   : vga_x, vga_y, vga_colour, vga_writeEn (to the VGA adapter)
//   Status       : busy, done, dbg_state (FSM state for observation)
//
// Handshake: the controller holds a request level-sensitive; the painter acts
// while the request stays asserted and unchanged, and pulses done for one
// cycle when a block or full clear completes. There is no per-pixel
// backpressure: vga_writeEn is a plain one-cycle write strobe.
// -----------------------------------------------------------------------------
interface snake_block_painter_if;
    import snake_gfx_pkg::*;

    logic [7:0] x_count;
    logic [6:0] y_count;
    logic [2:0] colour;
    logic       load_x;
    logic       load_y;
    logic       draw;
    logic       erase;
    logic       plot;
    logic       restart_game;

    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_writeEn;
    logic       busy;
    logic       done;
    state_t     dbg_state;

    modport master (
        output x_count, y_count, colour, load_x, load_y, draw, erase, plot,
               restart_game,
        input  vga_x, vga_y, vga_colour, vga_writeEn, busy, done, dbg_state
    );

    modport slave (
        input  x_count, y_count, colour, load_x, load_y, draw, erase, plot,
               restart_game,
        output vga_x, vga_y, vga_colour, vga_writeEn, busy, done, dbg_state
    );

endinterface

// File: rtl/snake_block_painter_xy_sweep_counter.sv
// -----------------------------------------------------------------------------
// xy_sweep_counter
// Row-major x/y counter with runtime limits. x is the inner count.
//   clk, rst_n    : clock, async active-low reset
//   clear         : synchronous return to (0,0), wins over step
//   step          : advance one position (wraps to (0,0) after (x_max,y_max))
//   x_max, y_max  : inclusive limits, may change between sweeps
//   x, y          : current position
//   last          : current position is (x_max, y_max)
// -----------------------------------------------------------------------------
module xy_sweep_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       step,
    input  logic [7:0] x_max,
    input  logic [6:0] y_max,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       last
);

    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (step) begin
            if (x_q == x_max) begin
                x_d = '0;
                y_d = (y_q == y_max) ? '0 : y_q + 7'd1;
            end else begin
                x_d = x_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == x_max) && (y_q == y_max);

endmodule

// File: rtl/snake_block_painter.sv
// -----------------------------------------------------------------------------
// snake_block_painter
// Turns held 4x4 block draw/erase requests into pixel writes for the VGA
// adapter, and clears the full 160x120 screen to black on restart_game.
//   CLOCK_50 : system clock
//   reset_n  : async active-low reset (all outputs and state to 0 / IDLE)
//   bus      : snake_block_painter_if.slave (command in, pixel writes out)
// All pixel outputs are registered: the pixel for counter position n is
// presented one cycle after the counter holds n.
// -----------------------------------------------------------------------------
module snake_block_painter
    import snake_gfx_pkg::*;
(
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    snake_block_painter_if.slave  bus
);

    state_t     state_q, state_d;
    key_t       key_q, key_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       vga_we_q, vga_we_d;
    logic       done_q, done_d;

    logic       req_blk, req_clr;
    logic [2:0] eff_colour;
    key_t       key_in;
    logic       key_changed;

    logic       cnt_clear, cnt_step, cnt_last;
    logic [7:0] cnt_x, cnt_x_max;
    logic [6:0] cnt_y, cnt_y_max;
    logic [8:0] blk_x;
    logic [7:0] blk_y;
    logic       blk_on_screen;

    // Erase wins over draw when both are raised.
    assign eff_colour  = bus.erase ? COLOUR_BLACK : bus.colour;
    assign key_in      = {bus.x_count, bus.y_count, eff_colour};
    assign key_changed = (key_in != key_q);

    assign req_clr = bus.plot & bus.restart_game;
    assign req_blk = bus.plot & bus.load_x & bus.load_y
                   & (bus.draw | bus.erase) & ~bus.restart_game;

    // The counter is always cleared on entry to PAINT/CLEAR, so selecting
    // the limits from the current state is enough.
    assign cnt_x_max = (state_q == CLEAR) ? 8'(SCREEN_W - 1) : 8'(BLOCK_EDGE - 1);
    assign cnt_y_max = (state_q == CLEAR) ? 7'(SCREEN_H - 1) : 7'(BLOCK_EDGE - 1);

    xy_sweep_counter u_sweep (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .clear (cnt_clear),
        .step  (cnt_step),
        .x_max (cnt_x_max),
        .y_max (cnt_y_max),
        .x     (cnt_x),
        .y     (cnt_y),
        .last  (cnt_last)
    );

    // Widened sums so blocks near the right/bottom edge clip instead of wrap.
    assign blk_x         = {1'b0, key_q.x} + {7'd0, cnt_x[1:0]};
    assign blk_y         = {1'b0, key_q.y} + {6'd0, cnt_y[1:0]};
    assign blk_on_screen = (blk_x < 9'(SCREEN_W)) && (blk_y < 8'(SCREEN_H));

    // State register and output registers
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            key_q        <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_we_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_we_q     <= vga_we_d;
            done_q       <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_clr)      state_d = CLEAR;
                else if (req_blk) state_d = PAINT;
            end
            PAINT: begin
                if (req_clr)           state_d = CLEAR;
                else if (!req_blk)     state_d = IDLE;
                else if (key_changed)  state_d = PAINT;
                else if (cnt_last)     state_d = HOLD;
            end
            HOLD: begin
                if (req_clr)                      state_d = CLEAR;
                else if (!req_blk || key_changed) state_d = IDLE;
            end
            CLEAR: begin
                if (!req_clr)      state_d = IDLE;
                else if (cnt_last) state_d = CLEAR_HOLD;
            end
            CLEAR_HOLD: begin
                if (!req_clr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath control
    always_comb begin
        key_d        = key_q;
        cnt_clear    = 1'b0;
        cnt_step     = 1'b0;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_we_d     = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
                if (req_blk) key_d = key_in;
            end
            PAINT: begin
                if (req_clr || !req_blk) begin
                    cnt_clear = 1'b1;
                end else if (key_changed) begin
                    // Restart on the new block; this slot writes nothing.
                    key_d     = key_in;
                    cnt_clear = 1'b1;
                end else begin
                    vga_x_d      = blk_x[7:0];
                    vga_y_d      = blk_y[6:0];
                    vga_colour_d = key_q.colour;
                    vga_we_d     = blk_on_screen;
                    done_d       = cnt_last;
                    cnt_step     = 1'b1;
                end
            end
            CLEAR: begin
                if (req_clr) begin
                    vga_x_d      = cnt_x;
                    vga_y_d      = cnt_y;
                    vga_colour_d = COLOUR_BLACK;
                    vga_we_d     = 1'b1;
                    done_d       = cnt_last;
                    cnt_step     = 1'b1;
                end else begin
                    cnt_clear = 1'b1;
                end
            end
            default: begin
                cnt_clear = 1'b1;
            end
        endcase
    end

    assign bus.vga_x       = vga_x_q;
    assign bus.vga_y       = vga_y_q;
    assign bus.vga_colour  = vga_colour_q;
    assign bus.vga_writeEn = vga_we_q;
    assign bus.done        = done_q;
    assign bus.busy        = (state_q == PAINT) || (state_q == CLEAR);
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_snake_block_painter.sv
// -----------------------------------------------------------------------------
// tb_snake_block_painter
// Directed and randomized block/clear requests; every pixel write and done
// pulse is captured and compared to a list built from the screen geometry.
// -----------------------------------------------------------------------------
module tb_snake_block_painter;
    import snake_gfx_pkg::*;

    typedef logic [17:0] pix_t;   // {x[7:0], y[6:0], colour[2:0]}

    logic CLOCK_50 = 1'b0;
    logic reset_n  = 1'b0;

    always #10 CLOCK_50 = ~CLOCK_50;

    snake_block_painter_if bus ();

    snake_block_painter dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    int unsigned cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    pix_t        got_q[$];
    pix_t        exp_q[$];
    int          done_cnt = 0;
    int unsigned done_cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    // Monitor: sample away from the active edge.
    always @(negedge CLOCK_50) begin
        if (bus.vga_writeEn === 1'b1)
            got_q.push_back({bus.vga_x, bus.vga_y, bus.vga_colour});
        if (bus.done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the pixels of a 4x4 block in row-major order, off-screen dropped.
    function automatic void model_block(input int bx, input int by, input logic [2:0] c);
        for (int dy = 0; dy < BLOCK_EDGE; dy++)
            for (int dx = 0; dx < BLOCK_EDGE; dx++)
                if (bx + dx < SCREEN_W && by + dy < SCREEN_H)
                    exp_q.push_back({8'(bx + dx), 7'(by + dy), c});
    endfunction

    task automatic drive_idle();
        bus.x_count = '0; bus.y_count = '0; bus.colour = '0;
        bus.load_x = 1'b0; bus.load_y = 1'b0; bus.draw = 1'b0; bus.erase = 1'b0;
        bus.plot = 1'b0; bus.restart_game = 1'b0;
    endtask

    task automatic drive_block(input int bx, input int by, input logic [2:0] c,
                               input logic dr, input logic er);
        bus.x_count = 8'(bx); bus.y_count = 7'(by); bus.colour = c;
        bus.load_x = 1'b1; bus.load_y = 1'b1; bus.draw = dr; bus.erase = er;
        bus.plot = 1'b1; bus.restart_game = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        int n;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_pix%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic reset_capture();
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    // Hold one block request for 'hold' cycles (>= 18), then release it.
    task automatic run_block(input string tag, input int bx, input int by,
                             input logic [2:0] c, input logic dr, input logic er,
                             input int hold);
        int unsigned req_cyc;
        reset_capture();
        @(posedge CLOCK_50); #1;
        drive_block(bx, by, c, dr, er);
        req_cyc = cyc;
        repeat (2) @(posedge CLOCK_50);
        #1;
        chk({tag, "_busy"}, bus.busy, 1'b1);
        repeat (hold - 2) @(posedge CLOCK_50);
        #1;
        chk({tag, "_hold_state"}, bus.dbg_state, HOLD);
        chk({tag, "_hold_busy"}, bus.busy, 1'b0);
        drive_idle();
        repeat (4) @(posedge CLOCK_50);
        #1;
        model_block(bx, by, er ? COLOUR_BLACK : c);
        check_writes(tag);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_done_lat"}, done_cyc - req_cyc, 17);
    endtask

    initial begin
        int w;
        int old_n;
        int bad;

        // Reset
        drive_idle();
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst_we", bus.vga_writeEn, 1'b0);
        chk("rst_x", bus.vga_x, 8'd0);
        chk("rst_y", bus.vga_y, 7'd0);
        chk("rst_colour", bus.vga_colour, 3'd0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_state", bus.dbg_state, IDLE);
        reset_n = 1'b1;
        repeat (2) @(posedge CLOCK_50);

        // Draw and erase
        run_block("draw", 60, 60, 3'b010, 1'b1, 1'b0, 22);
        run_block("erase", 48, 60, 3'b110, 1'b0, 1'b1, 22);
        run_block("draw_erase", 20, 10, 3'b101, 1'b1, 1'b1, 20);

        // Key change mid-paint
        reset_capture();
        @(posedge CLOCK_50); #1;
        drive_block(60, 60, 3'b010, 1'b1, 1'b0);
        w = 0;
        while (got_q.size() < 5 && w < 40) begin
            @(posedge CLOCK_50); #1;
            w++;
        end
        drive_block(56, 60, 3'b010, 1'b1, 1'b0);
        repeat (22) @(posedge CLOCK_50);
        #1;
        drive_idle();
        repeat (4) @(posedge CLOCK_50);
        #1;
        old_n = got_q.size() - 16;
        chk("kc_old_range", (old_n >= 5 && old_n < 16), 1'b1);
        if (old_n < 0) old_n = 0;
        model_block(60, 60, 3'b010);
        while (exp_q.size() > old_n) void'(exp_q.pop_back());
        model_block(56, 60, 3'b010);
        check_writes("kc");
        chk("kc_done_cnt", done_cnt, 1);

        // Clipping at the bottom-right corner
        run_block("clip", 158, 118, 3'($urandom_range(7, 1)), 1'b1, 1'b0, 22);

        // Full-screen clear
        reset_capture();
        @(posedge CLOCK_50); #1;
        bus.plot = 1'b1;
        bus.restart_game = 1'b1;
        w = 0;
        while (done_cnt == 0 && w < 20000) begin
            @(posedge CLOCK_50); #1;
            w++;
        end
        chk("clr_finished", (done_cnt != 0), 1'b1);
        repeat (10) @(posedge CLOCK_50);
        #1;
        chk("clr_count", got_q.size(), SCREEN_W * SCREEN_H);
        if (got_q.size() > 0) begin
            chk("clr_first", got_q[0], {8'd0, 7'd0, 3'd0});
            chk("clr_last", got_q[got_q.size() - 1], {8'd159, 7'd119, 3'd0});
        end
        bad = 0;
        for (int i = 0; i < got_q.size() && i < SCREEN_W * SCREEN_H; i++)
            if (got_q[i] !== {8'(i % SCREEN_W), 7'(i / SCREEN_W), COLOUR_BLACK})
                bad++;
        chk("clr_order_bad", bad, 0);
        chk("clr_done_cnt", done_cnt, 1);
        chk("clr_hold_state", bus.dbg_state, CLEAR_HOLD);
        chk("clr_hold_busy", bus.busy, 1'b0);
        drive_idle();
        repeat (2) @(posedge CLOCK_50);
        run_block("after_clr", 100, 40, 3'b011, 1'b1, 1'b0, 22);

        // Reset mid-clear
        @(posedge CLOCK_50); #1;
        bus.plot = 1'b1;
        bus.restart_game = 1'b1;
        repeat (100) @(posedge CLOCK_50);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we", bus.vga_writeEn, 1'b0);
        chk("mid_rst_x", bus.vga_x, 8'd0);
        chk("mid_rst_y", bus.vga_y, 7'd0);
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_state", bus.dbg_state, IDLE);
        drive_idle();
        @(posedge CLOCK_50); #1;
        reset_n = 1'b1;
        run_block("after_rst", 4, 4, 3'b111, 1'b1, 1'b0, 22);

        // Random blocks, biased toward the clipping edges half the time
        for (int k = 0; k < 8; k++) begin
            int bx, by;
            logic er;
            bx = (k % 2 == 0) ? int'($urandom_range(SCREEN_W - 1, 0))
                              : int'($urandom_range(SCREEN_W - 1, SCREEN_W - 4));
            by = (k % 2 == 0) ? int'($urandom_range(SCREEN_H - 1, 0))
                              : int'($urandom_range(SCREEN_H - 1, SCREEN_H - 4));
            er = 1'($urandom_range(1, 0));
            run_block($sformatf("rnd%0d", k), bx, by, 3'($urandom_range(7, 0)),
                      ~er, er, int'($urandom_range(24, 18)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
